dual_acc_regfile: RTL

Parametrised successor to the four-entry Double Accumulator Processor register file. It holds ACC, ACCO, SP, RA plus optional general registers, with two combinational read ports and one synchronous write port. It adds single-cycle ACC/ACCO swap, SP push/pop stepping with a sticky wrap fault, a dedicated RA link-write port and optional write-to-read bypass. It sits between decode and the ALU/stack logic of the datapath.

---
 rtl/dual_acc_regfile.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dual_acc_regfile.sv
// Register file for the double accumulator datapath: ACC, ACCO, SP, RA plus
// optional general registers, two combinational read ports, one write port.
module dual_acc_regfile #(
   parameter int                WIDTH    = 16,
   parameter int                NREGS    = 4,
   parameter int                ADDR_W   = $clog2(NREGS),
   parameter logic [WIDTH-1:0]  SP_RESET = {WIDTH{1'b0}},
   parameter int                SP_STEP  = 2,
   parameter bit                BYPASS   = 1'b1
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              write,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [WIDTH-1:0]  wrData,
   input  logic [ADDR_W-1:0] rdAddrA,
   input  logic [ADDR_W-1:0] rdAddrB,
   output logic [WIDTH-1:0]  rdDataA,
   output logic [WIDTH-1:0]  rdDataB,
   input  logic              swap,
   input  logic              spInc,
   input  logic              spDec,
   input  logic              linkWr,
   input  logic [WIDTH-1:0]  linkData,
   output logic [WIDTH-1:0]  ACCData,
   output logic [WIDTH-1:0]  ACCOData,
   output logic [WIDTH-1:0]  SPData,
   output logic [WIDTH-1:0]  RAData,
   output logic              spFault
);

   localparam int ACC_IDX  = 0;
   localparam int ACCO_IDX = 1;
   localparam int SP_IDX   = 2;
   localparam int RA_IDX   = 3;
   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(SP_STEP);

   logic [WIDTH-1:0] regFile_r [NREGS];
   logic [WIDTH-1:0] regNext_s [NREGS];
   logic             spFault_r;
   logic             faultNext_s;
   logic             stepFault_s;
   logic             wrValid_s;
   logic [WIDTH:0]   spSum_s;

   // Out-of-range addresses read as zero; bypass covers only the general write port
   function automatic logic [WIDTH-1:0] readMux(input logic [ADDR_W-1:0] addr);
      logic [WIDTH-1:0] val;
      if (int'(addr) >= NREGS) begin
         val = {WIDTH{1'b0}};
      end else if (BYPASS && write && (addr == wrAddr)) begin
         val = wrData;
      end else begin
         val = regFile_r[addr];
      end
      return val;
   endfunction

   // Next-state of every register and of the sticky fault flag
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regNext_s[i] = regFile_r[i];
      end
      stepFault_s = 1'b0;
      spSum_s     = {1'b0, regFile_r[SP_IDX]};
      wrValid_s   = write && (int'(wrAddr) < NREGS);

      if (swap) begin
         regNext_s[ACC_IDX]  = regFile_r[ACCO_IDX];
         regNext_s[ACCO_IDX] = regFile_r[ACC_IDX];
      end else begin
         regNext_s[ACC_IDX]  = regFile_r[ACC_IDX];
         regNext_s[ACCO_IDX] = regFile_r[ACCO_IDX];
      end

      // The extra MSB of the widened sum is the carry (inc) or borrow (dec)
      case ({spInc, spDec})
         2'b10: begin
            spSum_s               = {1'b0, regFile_r[SP_IDX]} + STEP_EXT;
            regNext_s[SP_IDX]     = spSum_s[WIDTH-1:0];
            stepFault_s           = spSum_s[WIDTH];
         end
         2'b01: begin
            spSum_s               = {1'b0, regFile_r[SP_IDX]} - STEP_EXT;
            regNext_s[SP_IDX]     = spSum_s[WIDTH-1:0];
            stepFault_s           = spSum_s[WIDTH];
         end
         default: begin
            regNext_s[SP_IDX]     = regFile_r[SP_IDX];
            stepFault_s           = 1'b0;
         end
      endcase

      if (linkWr) begin
         regNext_s[RA_IDX] = linkData;
      end else begin
         regNext_s[RA_IDX] = regFile_r[RA_IDX];
      end

      for (int i = 0; i < NREGS; i++) begin
         regNext_s[i] = (wrValid_s && (int'(wrAddr) == i)) ? wrData : regNext_s[i];
      end

      if (wrValid_s && (int'(wrAddr) == SP_IDX)) begin
         faultNext_s = 1'b0;
      end else begin
         faultNext_s = spFault_r | stepFault_s;
      end
   end

   // Register array and fault flag; reset drops any update pending this cycle
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regFile_r[i] <= (i == SP_IDX) ? SP_RESET : {WIDTH{1'b0}};
         end
         spFault_r <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regFile_r[i] <= regNext_s[i];
         end
         spFault_r <= faultNext_s;
      end
   end

   // Read ports and direct register taps
   always_comb begin
      rdDataA  = readMux(rdAddrA);
      rdDataB  = readMux(rdAddrB);
      ACCData  = regFile_r[ACC_IDX];
      ACCOData = regFile_r[ACCO_IDX];
      SPData   = regFile_r[SP_IDX];
      RAData   = regFile_r[RA_IDX];
      spFault  = spFault_r;
   end

endmodule
